// File: rtl/wb_stage.sv
// Writeback stage: registers the retiring instruction, waits for load data,
// formats it and drives the register-file write port and the instret counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic             mem_regwrite_i,
  input  logic             mem_is_load_i,
  input  logic [2:0]       mem_funct3_i,
  input  logic [1:0]       mem_addr_lo_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [XLEN-1:0]  mem_alu_result_i,
  input  logic             dm_rvalid_i,
  input  logic [XLEN-1:0]  dm_rdata_i,
  output logic             RegWrite,
  output logic [4:0]       rd_o,
  output logic [XLEN-1:0]  rd_value_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t r_state, w_next_state;

  logic [4:0]       r_rd;
  logic             r_regwrite;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;

  logic             r_wr;
  logic             r_retire;
  logic [4:0]       r_rd_o;
  logic [XLEN-1:0]  r_value;
  logic [CNT_W-1:0] r_instret;

  logic             w_accept;
  logic             w_retire;
  logic             w_wr;
  logic [4:0]       w_rd;
  logic [XLEN-1:0]  w_value;
  logic [XLEN-1:0]  w_load_data;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  // Load formatting uses the funct3/addr_lo captured at accept time.
  always_comb begin
    w_byte      = 8'h00;
    w_half      = 16'h0000;
    w_load_data = dm_rdata_i;
    case (r_addr_lo)
      2'd0:    w_byte = dm_rdata_i[7:0];
      2'd1:    w_byte = dm_rdata_i[15:8];
      2'd2:    w_byte = dm_rdata_i[23:16];
      default: w_byte = dm_rdata_i[31:24];
    endcase
    w_half = r_addr_lo[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = dm_rdata_i;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_retire     = 1'b0;
    w_wr         = 1'b0;
    w_rd         = r_rd_o;
    w_value      = r_value;
    mem_ready_o  = (r_state == IDLE);
    case (r_state)
      IDLE: begin
        if (mem_valid_i) begin
          w_accept = 1'b1;
          if (mem_is_load_i) begin
            w_next_state = WAIT_LOAD;
          end else begin
            w_retire = 1'b1;
            w_wr     = mem_regwrite_i && (mem_rd_i != 5'd0);
            w_rd     = mem_rd_i;
            w_value  = mem_alu_result_i;
          end
        end
      end
      WAIT_LOAD: begin
        if (dm_rvalid_i) begin
          w_next_state = IDLE;
          w_retire     = 1'b1;
          w_wr         = r_regwrite && (r_rd != 5'd0);
          w_rd         = r_rd;
          w_value      = w_load_data;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Write-port registers pulse for one cycle; rd/value hold between retirements.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_wr       <= 1'b0;
      r_retire   <= 1'b0;
      r_rd_o     <= 5'd0;
      r_value    <= '0;
      r_instret  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_wr     <= w_wr;
      r_retire <= w_retire;
      r_rd_o   <= w_rd;
      r_value  <= w_value;
      if (w_accept) begin
        r_rd       <= mem_rd_i;
        r_regwrite <= mem_regwrite_i;
        r_funct3   <= mem_funct3_i;
        r_addr_lo  <= mem_addr_lo_i;
      end
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign RegWrite   = r_wr;
  assign rd_o       = r_rd_o;
  assign rd_value_o = r_value;
  assign retire_o   = r_retire;
  assign instret_o  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal checks plus random traffic
// compared every cycle against a transaction-level model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memValid = 1'b0;
  logic        memRegwrite = 1'b0;
  logic        memIsLoad = 1'b0;
  logic [2:0]  memFunct3 = 3'd0;
  logic [1:0]  memAddrLo = 2'd0;
  logic [4:0]  memRd = 5'd0;
  logic [31:0] memAlu = 32'd0;
  logic        dmRvalid = 1'b0;
  logic [31:0] dmRdata = 32'd0;

  logic        memReady, regWrite, retire, memReady4, regWrite4, retire4;
  logic [4:0]  rdOut, rdOut4;
  logic [31:0] rdValue, rdValue4;
  logic [63:0] instret;
  logic [3:0]  instret4;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(memValid), .mem_ready_o(memReady),
    .mem_regwrite_i(memRegwrite), .mem_is_load_i(memIsLoad),
    .mem_funct3_i(memFunct3), .mem_addr_lo_i(memAddrLo),
    .mem_rd_i(memRd), .mem_alu_result_i(memAlu),
    .dm_rvalid_i(dmRvalid), .dm_rdata_i(dmRdata),
    .RegWrite(regWrite), .rd_o(rdOut), .rd_value_o(rdValue),
    .retire_o(retire), .instret_o(instret)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .mem_valid_i(memValid), .mem_ready_o(memReady4),
    .mem_regwrite_i(memRegwrite), .mem_is_load_i(memIsLoad),
    .mem_funct3_i(memFunct3), .mem_addr_lo_i(memAddrLo),
    .mem_rd_i(memRd), .mem_alu_result_i(memAlu),
    .dm_rvalid_i(dmRvalid), .dm_rdata_i(dmRdata),
    .RegWrite(regWrite4), .rd_o(rdOut4), .rd_value_o(rdValue4),
    .retire_o(retire4), .instret_o(instret4)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: one outstanding load, expected write port state.
  bit          busy = 1'b0;
  bit          pWe = 1'b0;
  bit [4:0]    pRd = 5'd0;
  bit [2:0]    pF3 = 3'd0;
  bit [1:0]    pAlo = 2'd0;
  bit          expReady = 1'b1;
  bit          expRetire = 1'b0;
  bit          expWe = 1'b0;
  bit [4:0]    expRd = 5'd0;
  bit [31:0]   expVal = 32'd0;
  bit [63:0]   expCnt = 64'd0;
  int          expCnt4 = 0;

  function automatic bit [31:0] fmtLoad(bit [2:0] f3, bit [1:0] alo, bit [31:0] word);
    bit [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * alo)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (word >> (alo[1] ? 16 : 0)) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic modelRetire(bit we, bit [4:0] rd, bit [31:0] val);
    expRetire = 1'b1;
    expWe     = we && (rd != 5'd0);
    expRd     = rd;
    expVal    = val;
    expCnt    = expCnt + 64'd1;
    expCnt4   = (expCnt4 + 1) % 16;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0; expRetire = 1'b0; expWe = 1'b0; expRd = 5'd0;
      expVal = 32'd0; expCnt = 64'd0; expCnt4 = 0;
    end else begin
      expRetire = 1'b0;
      expWe = 1'b0;
      if (busy) begin
        if (dmRvalid) begin
          modelRetire(pWe, pRd, fmtLoad(pF3, pAlo, dmRdata));
          busy = 1'b0;
        end
      end else if (memValid) begin
        if (memIsLoad) begin
          busy = 1'b1; pWe = memRegwrite; pRd = memRd; pF3 = memFunct3; pAlo = memAddrLo;
        end else begin
          modelRetire(memRegwrite, memRd, memAlu);
        end
      end
    end
    expReady = !busy;
  end

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("ready", 64'(memReady), 64'(expReady));
      checkOutput("retire", 64'(retire), 64'(expRetire));
      checkOutput("regwrite", 64'(regWrite), 64'(expWe));
      checkOutput("rd", 64'(rdOut), 64'(expRd));
      checkOutput("value", 64'(rdValue), 64'(expVal));
      checkOutput("instret", instret, expCnt);
      checkOutput("instret4", 64'(instret4), 64'(expCnt4));
    end
  end

  // Drives one cycle of inputs just after a rising edge, returns 1ns after the next one.
  task automatic applyStimulus(bit v, bit ld, bit we, bit [2:0] f3, bit [1:0] alo,
                               bit [4:0] rd, bit [31:0] alu, bit rv, bit [31:0] rdata, bit r);
    memValid = v; memIsLoad = ld; memRegwrite = we; memFunct3 = f3; memAddrLo = alo;
    memRd = rd; memAlu = alu; dmRvalid = rv; dmRdata = rdata; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(bit rv, bit [31:0] rdata);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, rv, rdata, 1'b0);
  endtask

  task automatic directedLoad(bit [2:0] f3, bit [1:0] alo, bit [31:0] want, string name);
    applyStimulus(1'b1, 1'b1, 1'b1, f3, alo, 5'd10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    checkOutput({name, "_ready_wait"}, 64'(memReady), 64'd0);
    checkOutput({name, "_no_early_retire"}, 64'(retire), 64'd0);
    idleCycle(1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);
    checkOutput({name, "_ready_wait2"}, 64'(memReady), 64'd0);
    idleCycle(1'b1, 32'h80FF_7F01);
    checkOutput({name, "_we"}, 64'(regWrite), 64'd1);
    checkOutput({name, "_rd"}, 64'(rdOut), 64'd10);
    checkOutput({name, "_value"}, 64'(rdValue), 64'(want));
    checkOutput({name, "_ready_back"}, 64'(memReady), 64'd1);
  endtask

  initial begin
    logic [63:0] base;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkEn = 1'b1;
    checkOutput("reset_ready", 64'(memReady), 64'd1);
    checkOutput("reset_we", 64'(regWrite), 64'd0);
    checkOutput("reset_retire", 64'(retire), 64'd0);
    checkOutput("reset_instret", instret, 64'd0);
    checkOutput("reset_value", 64'(rdValue), 64'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 5'd5, 32'h0000_1234, 1'b0, 32'd0, 1'b0);
    checkOutput("addi_we", 64'(regWrite), 64'd1);
    checkOutput("addi_rd", 64'(rdOut), 64'd5);
    checkOutput("addi_value", 64'(rdValue), 64'h1234);
    checkOutput("addi_retire", 64'(retire), 64'd1);
    checkOutput("addi_instret", instret, 64'd1);
    idleCycle(1'b0, 32'h0);
    checkOutput("hold_we", 64'(regWrite), 64'd0);
    checkOutput("hold_value", 64'(rdValue), 64'h1234);

    directedLoad(3'b000, 2'd3, 32'hFFFF_FF80, "lb");
    directedLoad(3'b100, 2'd3, 32'h0000_0080, "lbu");
    directedLoad(3'b001, 2'd2, 32'hFFFF_80FF, "lh");
    directedLoad(3'b101, 2'd1, 32'h0000_7F01, "lhu");
    directedLoad(3'b010, 2'd3, 32'h80FF_7F01, "lw");
    checkOutput("load_instret", instret, 64'd6);

    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 5'd0, 32'h55, 1'b0, 32'd0, 1'b0);
    checkOutput("x0_we", 64'(regWrite), 64'd0);
    checkOutput("x0_retire", 64'(retire), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 5'd7, 32'h66, 1'b0, 32'd0, 1'b0);
    checkOutput("store_we", 64'(regWrite), 64'd0);
    checkOutput("store_retire", 64'(retire), 64'd1);
    checkOutput("store_instret", instret, 64'd8);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 32'd0, 1'b0);
      checkOutput("b2b_we", 64'(regWrite), 64'd1);
      checkOutput("b2b_rd", 64'(rdOut), 64'(i + 1));
      checkOutput("b2b_value", 64'(rdValue), 64'h100 + 64'(i));
      checkOutput("b2b_ready", 64'(memReady), 64'd1);
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 3'b010, 2'd0, 5'd9, 32'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 5'd3, 32'h77, 1'b1, 32'h1234_5678, 1'b1);
    idleCycle(1'b1, 32'hCAFE_F00D);
    checkOutput("rstload_we", 64'(regWrite), 64'd0);
    checkOutput("rstload_retire", 64'(retire), 64'd0);
    checkOutput("rstload_instret", instret, 64'd0);
    checkOutput("rstload_ready", 64'(memReady), 64'd1);

    for (int i = 0; i < 17; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 5'd4, 32'(i), 1'b0, 32'd0, 1'b0);
    checkOutput("wrap_instret4", 64'(instret4), 64'd1);
    checkOutput("wrap_instret64", instret, 64'd17);
    base = instret;

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom),
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
                    $urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 199) == 0);
    end
    idleCycle(1'b0, 32'h0);
    idleCycle(1'b0, 32'h0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
